// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch stage of the pipelined MIPS core.
//
// Owns the PC, the instruction-memory request handshake and the IF/ID
// pipeline register. A three-state FSM tracks the outstanding request:
//   FETCH  : request at pc is outstanding.
//   BUFFER : a word has arrived while the pipeline is stalled. It is parked
//            in buf_q, so no refetch is needed and no request is issued.
//   DRAIN  : a branch redirected the pc while a request was still pending.
//            The orphaned request stays on drain_addr_q until it completes,
//            and its data is discarded.
//
// Handshake: the memory request is imem_req_out together with imem_addr_out.
// It completes on the rising edge where imem_req_out=1 and imem_ready_in=1.
// While it is pending, the address is held stable. Every request completes
// exactly once, and no request is abandoned by changing the address.
//
// Ports:
//   clock_in, reset_in         clock, synchronous active-high reset
//   pc_wr_in, if_id_wr_in      hazard-unit stalls (both 1 = advance)
//   branch_taken_in/target_in  ID-stage redirect, flushes IF/ID
//   imem_req_out/addr_out      instruction-memory request
//   imem_ready_in/data_in      instruction-memory response
//   if_id_*_out                IF/ID register contents
//   instruction2msb_out        IF/ID instruction[31:16] for the hazard unit
//   fsm_state_out              current FSM state (FETCH=0, BUFFER=1, DRAIN=2)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock_in,
  input  logic        reset_in,
  input  logic        pc_wr_in,
  input  logic        if_id_wr_in,
  input  logic        branch_taken_in,
  input  logic [31:0] branch_target_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ready_in,
  input  logic [31:0] imem_data_in,
  output logic [31:0] if_id_instruction_out,
  output logic [31:0] if_id_pc4_out,
  output logic        if_id_valid_out,
  output logic [15:0] instruction2msb_out,
  output logic [1:0]  fsm_state_out
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_BUFFER = 2'd1,
    S_DRAIN  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        advance;
  logic [31:0] pc_plus4;

  // If the two stall signals disagree, the stage stalls.
  assign advance  = pc_wr_in & if_id_wr_in;
  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= 32'h0;
      buf_q        <= 32'h0;
      instr_q      <= 32'h0;
      pc4_q        <= 32'h0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      buf_q        <= buf_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    buf_d        = buf_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;

    unique case (state_q)
      S_FETCH: begin
        if (branch_taken_in) begin
          // Flush: insert a NOP and keep pc4. If the request is still
          // pending, it must finish at its original address.
          pc_d    = branch_target_in;
          instr_d = 32'h0;
          valid_d = 1'b0;
          if (!imem_ready_in) begin
            drain_addr_d = pc_q;
            state_d      = S_DRAIN;
          end
        end else if (imem_ready_in) begin
          if (advance) begin
            instr_d = imem_data_in;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
          end else begin
            buf_d   = imem_data_in;
            state_d = S_BUFFER;
          end
        end
      end

      S_BUFFER: begin
        if (branch_taken_in) begin
          pc_d    = branch_target_in;
          instr_d = 32'h0;
          valid_d = 1'b0;
          buf_d   = 32'h0;
          state_d = S_FETCH;
        end else if (advance) begin
          instr_d = buf_q;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
          state_d = S_FETCH;
        end
      end

      S_DRAIN: begin
        // A further redirect may arrive while draining. It applies even in
        // the cycle where the orphaned request completes.
        if (branch_taken_in) begin
          pc_d    = branch_target_in;
          instr_d = 32'h0;
          valid_d = 1'b0;
        end
        if (imem_ready_in) begin
          state_d = S_FETCH;
        end
      end

      default: state_d = S_FETCH;
    endcase
  end

  // Request outputs depend only on registered state.
  assign imem_req_out          = (state_q != S_BUFFER);
  assign imem_addr_out         = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
  assign if_id_instruction_out = instr_q;
  assign if_id_pc4_out         = pc4_q;
  assign if_id_valid_out       = valid_q;
  assign instruction2msb_out   = instr_q[31:16];
  assign fsm_state_out         = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- directed self-checking bench for fetch_unit.
// Inputs change 1 ns after the rising edge. Request outputs are checked in
// the same cycle, before the next edge. Registered outputs are checked after
// the edge on which they are loaded.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0040_0000;
  localparam logic [1:0] ST_FETCH  = 2'd0;
  localparam logic [1:0] ST_BUFFER = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  logic        clk;
  logic        rst;
  logic        pc_wr;
  logic        if_id_wr;
  logic        br;
  logic [31:0] br_tgt;
  logic        req;
  logic [31:0] addr;
  logic        rdy;
  logic [31:0] data;
  logic [31:0] instr;
  logic [31:0] pc4;
  logic        valid;
  logic [15:0] msb;
  logic [1:0]  st;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clock_in              (clk),
    .reset_in              (rst),
    .pc_wr_in              (pc_wr),
    .if_id_wr_in           (if_id_wr),
    .branch_taken_in       (br),
    .branch_target_in      (br_tgt),
    .imem_req_out          (req),
    .imem_addr_out         (addr),
    .imem_ready_in         (rdy),
    .imem_data_in          (data),
    .if_id_instruction_out (instr),
    .if_id_pc4_out         (pc4),
    .if_id_valid_out       (valid),
    .instruction2msb_out   (msb),
    .fsm_state_out         (st)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic pw, input logic iw,
                       input logic b, input logic [31:0] t,
                       input logic rd, input logic [31:0] d);
    rst = r; pc_wr = pw; if_id_wr = iw; br = b; br_tgt = t; rdy = rd; data = d;
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 0, 32'h0, 1, 32'hFFFF_FFFF);
    tick(); tick();
    checks++; if (addr !== RPC) begin errors++; $display("FAIL reset_addr: got %h exp %h", addr, RPC); end
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL reset_req: got %b exp 1", req); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h exp 0", instr); end
    checks++; if (pc4 !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h exp 0", pc4); end
    checks++; if (st !== ST_FETCH) begin errors++; $display("FAIL reset_state: got %0d exp %0d", st, ST_FETCH); end
    drive(0, 1, 1, 0, 32'h0, 1, 32'h8C01_0004);
    tick();
    checks++; if (instr !== 32'h8C01_0004) begin errors++; $display("FAIL first_instr: got %h exp 8c010004", instr); end
    checks++; if (pc4 !== 32'h0040_0004) begin errors++; $display("FAIL first_pc4: got %h exp 00400004", pc4); end
    checks++; if (msb !== 16'h8C01) begin errors++; $display("FAIL first_msb: got %h exp 8c01", msb); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b exp 1", valid); end
    checks++; if (addr !== 32'h0040_0004) begin errors++; $display("FAIL first_next_addr: got %h exp 00400004", addr); end
  endtask

  // A branch whose request completes in the same cycle stays in FETCH, and
  // the returned word is dropped.
  task automatic test_branch_ready();
    drive(0, 1, 1, 1, 32'h0, 1, 32'hDEAD_BEEF);
    tick();
    checks++; if (addr !== 32'h0) begin errors++; $display("FAIL brrdy_addr: got %h exp 0", addr); end
    checks++; if (st !== ST_FETCH) begin errors++; $display("FAIL brrdy_state: got %0d exp %0d", st, ST_FETCH); end
    checks++; if (valid !== 1'b0 || instr !== 32'h0) begin errors++; $display("FAIL brrdy_flush: got v=%b i=%h exp v=0 i=0", valid, instr); end
    checks++; if (pc4 !== 32'h0040_0004) begin errors++; $display("FAIL brrdy_pc4_held: got %h exp 00400004", pc4); end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1, 0, 32'h0, 1, 32'h1000_0000 + i);
      checks++; if (addr !== 32'(4 * i) || req !== 1'b1) begin errors++; $display("FAIL stream_addr%0d: got %h req=%b exp %h req=1", i, addr, req, 4 * i); end
      tick();
      checks++; if (instr !== 32'h1000_0000 + i || pc4 !== 32'(4 * i + 4) || valid !== 1'b1) begin
        errors++; $display("FAIL stream_ifid%0d: got %h/%h/%b exp %h/%h/1", i, instr, pc4, valid, 32'h1000_0000 + i, 4 * i + 4);
      end
    end
  endtask

  task automatic test_branch_wait();
    // pc=0x10, request pending. Redirect to 0x100.
    drive(0, 1, 1, 1, 32'h100, 0, 32'h0);
    tick();
    checks++; if (valid !== 1'b0 || instr !== 32'h0) begin errors++; $display("FAIL brwait_flush: got v=%b i=%h exp v=0 i=0", valid, instr); end
    checks++; if (pc4 !== 32'h10) begin errors++; $display("FAIL brwait_pc4_held: got %h exp 10", pc4); end
    checks++; if (st !== ST_DRAIN) begin errors++; $display("FAIL brwait_state: got %0d exp %0d", st, ST_DRAIN); end
    drive(0, 1, 1, 0, 32'h0, 0, 32'h0);
    checks++; if (addr !== 32'h10 || req !== 1'b1) begin errors++; $display("FAIL drain_addr1: got %h req=%b exp 10 req=1", addr, req); end
    tick();
    checks++; if (addr !== 32'h10) begin errors++; $display("FAIL drain_addr2: got %h exp 10", addr); end
    drive(0, 1, 1, 0, 32'h0, 1, 32'hBADB_AD00);
    tick();
    checks++; if (valid !== 1'b0 || instr !== 32'h0) begin errors++; $display("FAIL drain_discard: got v=%b i=%h exp v=0 i=0", valid, instr); end
    checks++; if (addr !== 32'h100 || st !== ST_FETCH) begin errors++; $display("FAIL drain_exit: got %h st=%0d exp 100 st=0", addr, st); end
  endtask

  task automatic test_wait_states();
    drive(0, 1, 1, 0, 32'h0, 1, 32'h2000_0001);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 32'h0, 0, 32'hEEEE_0000 + i);
      tick();
      checks++; if (addr !== 32'h104 || req !== 1'b1) begin errors++; $display("FAIL wait_addr%0d: got %h req=%b exp 104 req=1", i, addr, req); end
      checks++; if (instr !== 32'h2000_0001 || pc4 !== 32'h104 || valid !== 1'b1) begin
        errors++; $display("FAIL wait_hold%0d: got %h/%h/%b exp 20000001/104/1", i, instr, pc4, valid);
      end
    end
    drive(0, 1, 1, 0, 32'h0, 1, 32'h2000_0002);
    tick();
    checks++; if (instr !== 32'h2000_0002 || pc4 !== 32'h108) begin errors++; $display("FAIL wait_load: got %h/%h exp 20000002/108", instr, pc4); end
    checks++; if (addr !== 32'h108) begin errors++; $display("FAIL wait_next_addr: got %h exp 108", addr); end
  endtask

  task automatic test_load_use_stall();
    // The hazard signals disagree here (pc_wr=1, if_id_wr=0), which counts as a stall.
    drive(0, 1, 0, 0, 32'h0, 1, 32'h0022_1820);
    tick();
    checks++; if (st !== ST_BUFFER || req !== 1'b0) begin errors++; $display("FAIL stall_buffer: got st=%0d req=%b exp st=1 req=0", st, req); end
    checks++; if (addr !== 32'h108 || instr !== 32'h2000_0002) begin errors++; $display("FAIL stall_hold: got %h/%h exp 108/20000002", addr, instr); end
    drive(0, 0, 0, 0, 32'h0, 0, 32'h7777_7777);
    tick();
    checks++; if (st !== ST_BUFFER || req !== 1'b0) begin errors++; $display("FAIL stall_buffer2: got st=%0d req=%b exp st=1 req=0", st, req); end
    drive(0, 1, 1, 0, 32'h0, 1, 32'hFFFF_FFFF);
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL stall_no_req: got %b exp 0", req); end
    tick();
    checks++; if (instr !== 32'h0022_1820 || pc4 !== 32'h10C || valid !== 1'b1) begin
      errors++; $display("FAIL stall_release: got %h/%h/%b exp 00221820/10c/1", instr, pc4, valid);
    end
    checks++; if (st !== ST_FETCH || addr !== 32'h10C) begin errors++; $display("FAIL stall_resume: got st=%0d %h exp st=0 10c", st, addr); end
  endtask

  task automatic test_branch_stall();
    drive(0, 1, 0, 0, 32'h0, 1, 32'h3333_3333);
    tick();
    drive(0, 1, 0, 1, 32'h200, 0, 32'h0);
    tick();
    checks++; if (valid !== 1'b0 || instr !== 32'h0 || pc4 !== 32'h10C) begin
      errors++; $display("FAIL brstall_flush: got %b/%h/%h exp 0/0/10c", valid, instr, pc4);
    end
    checks++; if (st !== ST_FETCH || addr !== 32'h200 || req !== 1'b1) begin
      errors++; $display("FAIL brstall_fetch: got st=%0d %h req=%b exp st=0 200 req=1", st, addr, req);
    end
    drive(0, 1, 1, 0, 32'h0, 1, 32'h4444_4444);
    tick();
    checks++; if (instr !== 32'h4444_4444 || pc4 !== 32'h204) begin errors++; $display("FAIL brstall_buf_dropped: got %h/%h exp 44444444/204", instr, pc4); end
  endtask

  task automatic test_pc_wrap();
    drive(0, 1, 1, 1, 32'hFFFF_FFFC, 1, 32'h0);
    tick();
    drive(0, 1, 1, 0, 32'h0, 1, 32'h0000_0055);
    checks++; if (addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got %h exp fffffffc", addr); end
    tick();
    checks++; if (pc4 !== 32'h0 || addr !== 32'h0 || instr !== 32'h55) begin errors++; $display("FAIL wrap_pc4: got %h/%h/%h exp 0/0/55", pc4, addr, instr); end
  endtask

  task automatic test_drain_rebranch_and_reset();
    drive(0, 1, 1, 1, 32'h300, 0, 32'h0);
    tick();
    // A second redirect while draining, in the same cycle the orphaned request completes.
    drive(0, 1, 1, 1, 32'h340, 1, 32'h9999_9999);
    checks++; if (addr !== 32'h0 || st !== ST_DRAIN) begin errors++; $display("FAIL rebr_drain_addr: got %h st=%0d exp 0 st=2", addr, st); end
    tick();
    checks++; if (addr !== 32'h340 || st !== ST_FETCH || valid !== 1'b0) begin
      errors++; $display("FAIL rebr_target: got %h st=%0d v=%b exp 340 st=0 v=0", addr, st, valid);
    end
    drive(0, 1, 1, 1, 32'h500, 0, 32'h0);
    tick();
    drive(1, 1, 1, 0, 32'h0, 0, 32'h0);
    tick();
    checks++; if (st !== ST_FETCH || addr !== RPC || req !== 1'b1) begin
      errors++; $display("FAIL reset_drain: got st=%0d %h req=%b exp st=0 %h req=1", st, addr, req, RPC);
    end
    checks++; if (pc4 !== 32'h0 || valid !== 1'b0) begin errors++; $display("FAIL reset_drain_ifid: got %h/%b exp 0/0", pc4, valid); end
    drive(0, 1, 1, 0, 32'h0, 0, 32'h0);
    tick();
  endtask

  initial begin
    drive(1, 1, 1, 0, 32'h0, 0, 32'h0);
    test_reset();
    test_branch_ready();
    test_streaming();
    test_branch_wait();
    test_wait_states();
    test_load_use_stall();
    test_branch_stall();
    test_pc_wrap();
    test_drain_rebranch_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined MIPS core. It owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register. It consumes the hazard unit's `pc_wr`/`if_id_wr` stall signals and the ID-stage branch redirect. It supplies the IF/ID instruction, including the 16 MSBs the hazard unit decodes.

## Interface

- Clocking: one clock; reset is synchronous and active-high.

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

Ports:
- `clock_in`  input  1  pipeline clock; all state updates on rising edge.
- `reset_in`  input  1  synchronous, active-high reset.
- `pc_wr_in`  input  1  from the hazard unit; 0 means hold the PC.
- `if_id_wr_in`  input  1  from the hazard unit; 0 means hold IF/ID.
- `branch_taken_in`  input  1  ID-stage redirect; flushes IF/ID.
- `branch_target_in`  input  32  redirect PC, valid when `branch_taken_in`=1.
- `imem_req_out`  output  1  instruction-memory request.
- `imem_addr_out`  output  32  fetch address.
- `imem_ready_in`  input  1  memory has `imem_data_in` valid this cycle.
- `imem_data_in`  input  32  fetched instruction word.
- `if_id_instruction_out`  output  32  IF/ID instruction.
- `if_id_pc4_out`  output  32  IF/ID PC+4.
- `if_id_valid_out`  output  1  IF/ID holds a real instruction.
- `instruction2msb_out`  output  16  equals `if_id_instruction_out[31:16]`; goes to the hazard unit.

## Operation

Definitions:
- `advance` = `pc_wr_in` & `if_id_wr_in`. If the two disagree, the unit treats it as a stall.
- Fetch word: `imem_data_in` in FETCH when ready=1, or the buffered word in BUFFER.

FSM has three states.

FETCH (`imem_req_out`=1, `imem_addr_out`=pc):
- `branch_taken_in` & !ready: pc<=target, flush IF/ID, go to DRAIN. `drain_addr` is loaded with the old pc.
- `branch_taken_in` & ready: pc<=target, flush IF/ID, discard the data, stay in FETCH.
- ready & `advance`: IF/ID<={data, pc+4, valid=1}, pc<=pc+4, stay in FETCH.
- ready & !`advance`: buf<=data, hold IF/ID and pc, go to BUFFER.
- !ready: hold everything.

BUFFER (`imem_req_out`=0, `imem_addr_out`=pc):
- `branch_taken_in`: pc<=target, flush IF/ID, drop buf, go to FETCH.
- `advance`: IF/ID<={buf, pc+4, valid=1}, pc<=pc+4, go to FETCH.
- Otherwise: hold.

DRAIN (`imem_req_out`=1, `imem_addr_out`=`drain_addr`):
- ready: discard the data, go to FETCH at the current pc.
- `branch_taken_in`: pc<=new target and flush again. This applies in the same cycle as the ready case if both occur; DRAIN is left only on ready.

Flush:
- if_id_instruction<=32'h0 (NOP), if_id_valid<=0, if_id_pc4 held.

Priority: reset > `branch_taken_in` > `advance` > hold.

Handshake rules:
- While `imem_req_out`=1 and ready=0, `imem_addr_out` stays stable.
- Each request completes exactly once. A response is never dropped by re-issuing a new address.

Arithmetic:
- pc+4 is 32-bit and wraps modulo 2^32.
- `branch_target_in` is used as given. Alignment is not checked.

## Timing

Reset, in the cycle after `reset_in` sampled high:
- pc=`RESET_PC`, state=FETCH.
- `imem_req_out`=1, `imem_addr_out`=`RESET_PC`.
- if_id_instruction=0, if_id_pc4=0, if_id_valid=0, buf=0.

Reset mid-DRAIN or mid-BUFFER returns to FETCH. Instruction memory shares the same reset, so no stale response follows.

Latency and throughput:
- Data is visible on IF/ID outputs one cycle after the ready edge when advancing.
- Zero-wait memory (ready tied 1, no stalls) gives 1 instruction/cycle.
- A stall costs no refetch: BUFFER holds the word.
- A taken branch costs 1 flushed slot. In DRAIN it also costs the remaining wait cycles of the orphaned request.

Output derivation:
- `instruction2msb_out` is combinational from the IF/ID register.
- `imem_req_out` and `imem_addr_out` are functions of state and registers only. There is no combinational path from any input.

## Test plan

- **Reset:** hold reset 2 cycles with `RESET_PC`=32'h0040_0000 → addr=0x0040_0000, req=1, valid=0, instruction=0. Release, ready=1 and data=0x8C01_0004 → next cycle instruction=0x8C01_0004, pc4=0x0040_0004, `instruction2msb_out`=0x8C01.
- **Streaming:** ready=1, no stalls, 4 cycles → addr sequence 0x0, 0x4, 0x8, 0xC; IF/ID updates every cycle; valid=1.
- **Wait states:** ready low for 3 cycles at addr 0x8 → addr is stable at 0x8 all 3 cycles; IF/ID and pc are held; load occurs on the ready cycle.
- **Load-use stall:** `pc_wr_in`=`if_id_wr_in`=0 for 2 cycles while ready=1 with data 0x0022_1820 → BUFFER entered and req=0; on release, IF/ID=0x0022_1820 with no extra memory request.
- **Branch during wait:** at pc=0x10 with ready=0, branch to 0x100 → IF/ID flushed (valid=0, instruction=0); addr stays 0x10 until ready; that data is discarded; next request is to 0x100.
- **Branch plus stall:** `branch_taken_in`=1, target 0x200, with `if_id_wr_in`=0 in BUFFER → flush still happens; buf dropped; FETCH at 0x200.
